// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, aluOP codes, immediate formats and the decoded control bundle.
// Used by rv_imm_gen and rv_decode_stage; the M-extension codes are only reachable when RV_MEXT_EN is defined.
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [5:0] ALUOP_LOAD   = 6'd0;
  localparam logic [5:0] ALUOP_IMM    = 6'd5;
  localparam logic [5:0] ALUOP_SRLI   = 6'd10;
  localparam logic [5:0] ALUOP_SRAI   = 6'd11;
  localparam logic [5:0] ALUOP_STORE  = 6'd14;
  localparam logic [5:0] ALUOP_ADD    = 6'd18;
  localparam logic [5:0] ALUOP_SUB    = 6'd19;
  localparam logic [5:0] ALUOP_SRL    = 6'd24;
  localparam logic [5:0] ALUOP_SRA    = 6'd25;
  localparam logic [5:0] ALUOP_BRANCH = 6'd28;
  localparam logic [5:0] ALUOP_JAL    = 6'd34;
  localparam logic [5:0] ALUOP_JALR   = 6'd35;
  localparam logic [5:0] ALUOP_LUI    = 6'd36;
  localparam logic [5:0] ALUOP_AUIPC  = 6'd37;
  localparam logic [5:0] ALUOP_MEXT   = 6'd38;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       operand_a;
    logic       operand_b;
    logic       branch;
    logic       jalr_en;
    logic       jal_en;
    logic [5:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Most aluOP groups are a base code plus funct3.
  function automatic logic [5:0] alu_off(input logic [5:0] base, input logic [2:0] funct3);
    return base + {3'b000, funct3};
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate generator: selects the I/S/B/U/J bit layout and sign-extends to XLEN.
// FMT_R (and anything unrecognised) yields zero.
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]             instr,
  input  imm_fmt_t                fmt,
  output logic signed [XLEN-1:0]  imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast sign-extends for XLEN=64.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, flush and a one-bubble load-use interlock.
// Define RV_MEXT_EN to decode the M-extension (mul/div/rem); otherwise those encodings are illegal.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic signed [XLEN-1:0]  out_imm,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [4:0]              out_rd,
  output logic                    out_reg_write,
  output logic                    out_mem_to_reg,
  output logic                    out_mem_write,
  output logic                    out_operand_a,
  output logic                    out_operand_b,
  output logic                    out_branch,
  output logic                    out_jalr_en,
  output logic                    out_jal_en,
  output logic [ALUOP_W-1:0]      out_alu_op,
  output logic                    out_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign alt    = in_instr[30];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign rd_f   = in_instr[11:7];

  ctrl_t                   dec_p0;
  imm_fmt_t                fmt_p0;
  logic signed [XLEN-1:0]  imm_p0;

  // Stage 0: combinational decode of the offered instruction
  always_comb begin
    dec_p0 = '0;
    fmt_p0 = FMT_R;
    case (opcode)
      OP_LOAD: begin
        if (funct3 <= 3'd4) begin
          fmt_p0            = FMT_I;
          dec_p0.rs1        = rs1_f;
          dec_p0.rd         = rd_f;
          dec_p0.reg_write  = 1'b1;
          dec_p0.mem_to_reg = 1'b1;
          dec_p0.operand_a  = 1'b1;
          dec_p0.alu_op     = alu_off(ALUOP_LOAD, funct3);
        end else begin
          dec_p0.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        fmt_p0           = FMT_I;
        dec_p0.rs1       = rs1_f;
        dec_p0.rd        = rd_f;
        dec_p0.reg_write = 1'b1;
        dec_p0.operand_a = 1'b1;
        case (funct3)
          3'd5:       dec_p0.alu_op = alt ? ALUOP_SRAI : ALUOP_SRLI;
          3'd6, 3'd7: dec_p0.alu_op = alu_off(ALUOP_IMM + 6'd1, funct3);
          default:    dec_p0.alu_op = alu_off(ALUOP_IMM, funct3);
        endcase
      end
      OP_STORE: begin
        if (funct3 <= 3'd2) begin
          fmt_p0           = FMT_S;
          dec_p0.rs1       = rs1_f;
          dec_p0.rs2       = rs2_f;
          dec_p0.mem_write = 1'b1;
          dec_p0.operand_a = 1'b1;
          dec_p0.alu_op    = alu_off(ALUOP_STORE, funct3);
        end else begin
          dec_p0.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 != 3'd2 && funct3 != 3'd3) begin
          fmt_p0        = FMT_B;
          dec_p0.rs1    = rs1_f;
          dec_p0.rs2    = rs2_f;
          dec_p0.branch = 1'b1;
          // funct3 4..7 skip the two unused encodings to land on 30..33.
          dec_p0.alu_op = funct3[2] ? alu_off(ALUOP_BRANCH - 6'd2, funct3)
                                    : alu_off(ALUOP_BRANCH, funct3);
        end else begin
          dec_p0.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        fmt_p0           = FMT_J;
        dec_p0.rd        = rd_f;
        dec_p0.reg_write = 1'b1;
        dec_p0.jal_en    = 1'b1;
        dec_p0.alu_op    = ALUOP_JAL;
      end
      OP_JALR: begin
        fmt_p0           = FMT_I;
        dec_p0.rs1       = rs1_f;
        dec_p0.rd        = rd_f;
        dec_p0.reg_write = 1'b1;
        dec_p0.operand_a = 1'b1;
        dec_p0.jalr_en   = 1'b1;
        dec_p0.alu_op    = ALUOP_JALR;
      end
      OP_LUI: begin
        fmt_p0           = FMT_U;
        dec_p0.rd        = rd_f;
        dec_p0.reg_write = 1'b1;
        dec_p0.operand_a = 1'b1;
        dec_p0.alu_op    = ALUOP_LUI;
      end
      OP_AUIPC: begin
        fmt_p0           = FMT_U;
        dec_p0.rd        = rd_f;
        dec_p0.reg_write = 1'b1;
        dec_p0.operand_a = 1'b1;
        dec_p0.operand_b = 1'b1;
        dec_p0.alu_op    = ALUOP_AUIPC;
      end
      OP_REG: begin
        if (funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          dec_p0.rs1       = rs1_f;
          dec_p0.rs2       = rs2_f;
          dec_p0.rd        = rd_f;
          dec_p0.reg_write = 1'b1;
          case (funct3)
            3'd0:       dec_p0.alu_op = alt ? ALUOP_SUB : ALUOP_ADD;
            3'd5:       dec_p0.alu_op = alt ? ALUOP_SRA : ALUOP_SRL;
            3'd6, 3'd7: dec_p0.alu_op = alu_off(ALUOP_ADD + 6'd2, funct3);
            default:    dec_p0.alu_op = alu_off(ALUOP_ADD + 6'd1, funct3);
          endcase
        end
`ifdef RV_MEXT_EN
        else if (funct7 == F7_MEXT) begin
          dec_p0.rs1       = rs1_f;
          dec_p0.rs2       = rs2_f;
          dec_p0.rd        = rd_f;
          dec_p0.reg_write = 1'b1;
          dec_p0.alu_op    = alu_off(ALUOP_MEXT, funct3);
        end
`endif
        else begin
          dec_p0.illegal = 1'b1;
        end
      end
      default: dec_p0.illegal = 1'b1;
    endcase
  end

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt_p0),
    .imm   (imm_p0)
  );

  ctrl_t                   ctrl_p1;
  logic [XLEN-1:0]         pc_p1;
  logic signed [XLEN-1:0]  imm_p1;
  logic                    vld_p1;
  logic                    trk_vld_p1;
  logic [4:0]              trk_rd_p1;
  logic                    hazard;
  logic                    accept;
  logic                    fire;

  // Decoded rs fields are already 0 when unused, and a tracked rd is never 0.
  assign hazard   = trk_vld_p1 && in_valid &&
                    (dec_p0.rs1 == trk_rd_p1 || dec_p0.rs2 == trk_rd_p1);
  assign in_ready = !reset && (!vld_p1 || out_ready) && !hazard;
  assign accept   = in_valid && in_ready && !flush;
  assign fire     = vld_p1 && out_ready;

  // Stage 1: output register and single-cycle load-rd tracker
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      pc_p1      <= '0;
      imm_p1     <= '0;
      trk_vld_p1 <= 1'b0;
      trk_rd_p1  <= '0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
      trk_vld_p1 <= 1'b0;
    end else begin
      trk_vld_p1 <= fire && ctrl_p1.mem_to_reg && (ctrl_p1.rd != 5'd0);
      trk_rd_p1  <= ctrl_p1.rd;
      if (accept) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= dec_p0;
        pc_p1   <= in_pc;
        imm_p1  <= imm_p0;
      end else if (fire) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid      = vld_p1;
  assign out_pc         = pc_p1;
  assign out_imm        = imm_p1;
  assign out_rs1        = ctrl_p1.rs1;
  assign out_rs2        = ctrl_p1.rs2;
  assign out_rd         = ctrl_p1.rd;
  assign out_reg_write  = ctrl_p1.reg_write;
  assign out_mem_to_reg = ctrl_p1.mem_to_reg;
  assign out_mem_write  = ctrl_p1.mem_write;
  assign out_operand_a  = ctrl_p1.operand_a;
  assign out_operand_b  = ctrl_p1.operand_b;
  assign out_branch     = ctrl_p1.branch;
  assign out_jalr_en    = ctrl_p1.jalr_en;
  assign out_jal_en     = ctrl_p1.jal_en;
  assign out_alu_op     = ALUOP_W'(ctrl_p1.alu_op);
  assign out_illegal    = ctrl_p1.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed instructions with hand-computed bundles,
// plus stall, load-use, flush and reset cases. Honours RV_MEXT_EN for the mul expectation.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic signed [31:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write, out_mem_to_reg, out_mem_write, out_operand_a, out_operand_b;
  logic        out_branch, out_jalr_en, out_jal_en, out_illegal;
  logic [5:0]  out_alu_op;

  rv_decode_stage #(.XLEN(32), .ALUOP_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
    .out_operand_a(out_operand_a), .out_operand_b(out_operand_b), .out_branch(out_branch),
    .out_jalr_en(out_jalr_en), .out_jal_en(out_jal_en), .out_alu_op(out_alu_op),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Bundle layout: pc, imm, rs1, rs2, rd, {regW,memToReg,memW,opA,opB,branch,jalr,jal}, alu_op, illegal
  logic [93:0] act;
  assign act = {out_pc, out_imm, out_rs1, out_rs2, out_rd,
                out_reg_write, out_mem_to_reg, out_mem_write, out_operand_a, out_operand_b,
                out_branch, out_jalr_en, out_jal_en, out_alu_op, out_illegal};

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [93:0] exp_q[$];
  string       nm_q[$];

  function automatic logic [93:0] mk(input logic [31:0] pc, input logic [31:0] imm,
                                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                     input logic [7:0] ctl, input logic [5:0] alu, input logic ill);
    return {pc, imm, r1, r2, rd, ctl, alu, ill};
  endfunction

  task automatic chk(input string nm, input logic [93:0] got, input logic [93:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [93:0] e, input string nm);
    bit acc;
    acc = 1'b0;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total_cnt++;
      $display("FAIL %s: not accepted within 20 cycles", nm);
    end
  endtask

  // Monitor: every firing bundle is popped against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_fire: got %h expected no output", act);
      end else begin
        chk(nm_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [93:0] e_mul, e_addi_hold;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, act}, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(32'hFFF08293, 32'h100, mk(32'h100, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd5, 8'b1001_0000, 6'd5,  1'b0), "addi");
    issue(32'h402081B3, 32'h104, mk(32'h104, 32'h0,        5'd1, 5'd2, 5'd3, 8'b1000_0000, 6'd19, 1'b0), "sub");
    issue(32'h0020A423, 32'h108, mk(32'h108, 32'h8,        5'd1, 5'd2, 5'd0, 8'b0011_0000, 6'd16, 1'b0), "sw");
    issue(32'h123453B7, 32'h10C, mk(32'h10C, 32'h12345000, 5'd0, 5'd0, 5'd7, 8'b1001_0000, 6'd36, 1'b0), "lui");
    issue(32'hFE208EE3, 32'h110, mk(32'h110, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 8'b0000_0100, 6'd28, 1'b0), "beq");
    issue(32'h008000EF, 32'h114, mk(32'h114, 32'h8,        5'd0, 5'd0, 5'd1, 8'b1000_0001, 6'd34, 1'b0), "jal");
    issue(32'h004100E7, 32'h118, mk(32'h118, 32'h4,        5'd2, 5'd0, 5'd1, 8'b1001_0010, 6'd35, 1'b0), "jalr");
    issue(32'h00001217, 32'h11C, mk(32'h11C, 32'h1000,     5'd0, 5'd0, 5'd4, 8'b1001_1000, 6'd37, 1'b0), "auipc");
    issue(32'h4020D193, 32'h120, mk(32'h120, 32'h402,      5'd1, 5'd0, 5'd3, 8'b1001_0000, 6'd11, 1'b0), "srai");
    issue(32'h0000007F, 32'h124, mk(32'h124, 32'h0,        5'd0, 5'd0, 5'd0, 8'b0000_0000, 6'd0,  1'b1), "bad_opcode");
    issue(32'h00002063, 32'h128, mk(32'h128, 32'h0,        5'd0, 5'd0, 5'd0, 8'b0000_0000, 6'd0,  1'b1), "branch_f3_2");
`ifdef RV_MEXT_EN
    e_mul = mk(32'h12C, 32'h0, 5'd2, 5'd3, 5'd1, 8'b1000_0000, 6'd38, 1'b0);
`else
    e_mul = mk(32'h12C, 32'h0, 5'd0, 5'd0, 5'd0, 8'b0000_0000, 6'd0, 1'b1);
`endif
    issue(32'h023100B3, 32'h12C, e_mul, "mul");
    repeat (2) @(posedge clk); #1;

    // Load-use: lw x5 fires, then add x6,x5,x2 is offered in the following cycle.
    issue(32'h0000A283, 32'h140, mk(32'h140, 32'h0, 5'd1, 5'd0, 5'd5, 8'b1101_0000, 6'd2, 1'b0), "lw");
    @(posedge clk); #1;
    in_instr = 32'h00228333; in_pc = 32'h144; in_valid = 1'b1;
    @(negedge clk);
    chk("hazard_in_ready", {93'd0, in_ready}, 94'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_out_valid", {93'd0, out_valid}, 94'd0);
    chk("after_hazard_in_ready", {93'd0, in_ready}, 94'd1);
    exp_q.push_back(mk(32'h144, 32'h0, 5'd5, 5'd2, 5'd6, 8'b1000_0000, 6'd18, 1'b0));
    nm_q.push_back("add_after_lw");
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Back-pressure: bundle must hold for 3 cycles and then fire exactly once.
    out_ready = 1'b0;
    e_addi_hold = mk(32'h200, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd5, 8'b1001_0000, 6'd5, 1'b0);
    issue(32'hFFF08293, 32'h200, e_addi_hold, "addi_held");
    in_instr = 32'h402081B3; in_pc = 32'h204; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_bundle", {out_valid, act[92:0]}, {1'b1, e_addi_hold[92:0]});
      chk("held_in_ready", {93'd0, in_ready}, 94'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(32'h402081B3, 32'h204, mk(32'h204, 32'h0, 5'd1, 5'd2, 5'd3, 8'b1000_0000, 6'd19, 1'b0), "sub_after_stall");
    repeat (2) @(posedge clk); #1;

    // Flush with a held bundle and a pending input.
    out_ready = 1'b0;
    issue(32'h123453B7, 32'h300, mk(32'h300, 32'h12345000, 5'd0, 5'd0, 5'd7, 8'b1001_0000, 6'd36, 1'b0), "lui_flushed");
    flush = 1'b1; in_instr = 32'h00228333; in_pc = 32'h304; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    void'(exp_q.pop_back());
    void'(nm_q.pop_back());
    @(negedge clk);
    chk("flush_held_out_valid", {92'd0, out_valid, in_ready}, 94'd1);
    @(posedge clk); #1;

    // Flush while idle: input offered with in_ready high must still be dropped.
    flush = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h308; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_idle_in_ready", {93'd0, in_ready}, 94'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_out_valid", {93'd0, out_valid}, 94'd0);
    @(posedge clk); #1;
    chk("scoreboard_drained", 94'(exp_q.size()), 94'd0);

    // Reset mid-operation discards the held bundle.
    out_ready = 1'b0;
    issue(32'hFFF08293, 32'h400, mk(32'h400, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd5, 8'b1001_0000, 6'd5, 1'b0), "addi_reset");
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {93'd0, in_ready}, 94'd0);
    @(posedge clk); #1;
    exp_q.delete();
    nm_q.delete();
    @(negedge clk);
    chk("mid_reset_state", {out_valid, act}, '0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid", {93'd0, out_valid}, 94'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
